// File: rtl/i2c_master_if.sv
`default_nettype none
//============================================================================
// Module   : i2c_master_if
// Brief    : Command/status bundle between the front end and i2c_master.
// Revision : 1.0 - initial release
//============================================================================
interface i2c_master_if;
   logic       cmd_start;
   logic       cmd_write;
   logic       cmd_read;
   logic       cmd_stop;
   logic [7:0] tx_data;
   logic       master_ack;
   logic [7:0] rx_data;
   logic       ack_in;
   logic       busy;
   logic       done;
   logic       bus_owned;

   modport master (
      input  cmd_start, cmd_write, cmd_read, cmd_stop, tx_data, master_ack,
      output rx_data, ack_in, busy, done, bus_owned
   );

   modport slave (
      output cmd_start, cmd_write, cmd_read, cmd_stop, tx_data, master_ack,
      input  rx_data, ack_in, busy, done, bus_owned
   );
endinterface
`default_nettype wire

// File: rtl/i2c_master.sv
`default_nettype none
//============================================================================
// Module   : i2c_master
// Brief    : Byte-level I2C master, one bus primitive per accepted command.
// Revision : 1.0 - initial release
//============================================================================
module i2c_master #(
   parameter int CLK_DIV = 250
) (
   input  wire logic    clk,
   input  wire logic    reset,
   i2c_master_if.master ctl,
   output logic         SCL,
   inout  wire          SDA
);

   localparam logic [15:0] c_q_last = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WBIT  = 3'd2,
      S_WACK  = 3'd3,
      S_RBIT  = 3'd4,
      S_RACK  = 3'd5,
      S_STOP  = 3'd6,
      S_HOLD  = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_qcnt;
   logic [1:0]  r_quarter;
   logic [2:0]  r_bit;
   logic [7:0]  r_tx;
   logic [7:0]  r_rx_sr;
   logic [7:0]  r_rx_data;
   logic        r_mack;
   logic        r_ack_smp;
   logic        r_ack_in;
   logic        r_done;
   logic        r_owned;
   logic        r_scl;
   logic        r_sda_low;
   logic [1:0]  r_sda_sync;

   logic        w_q_last;
   logic        w_cell_end;
   logic        w_sample;
   logic        w_idle_like;
   logic        w_accept;
   logic        w_finish;
   logic        w_scl;
   logic        w_sda_low;
   logic        w_scl_cell;

   assign w_q_last    = (r_qcnt == c_q_last);
   assign w_cell_end  = w_q_last && (r_quarter == 2'd3);
   assign w_sample    = w_q_last && (r_quarter == 2'd2);
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HOLD);
   assign w_scl_cell  = (r_quarter == 2'd1) || (r_quarter == 2'd2);
   // Data/address primitives are only meaningful once the bus is owned.
   assign w_accept    = w_idle_like &&
                        (ctl.cmd_start ||
                         (r_owned && (ctl.cmd_stop || ctl.cmd_write || ctl.cmd_read)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_finish    = 1'b0;
      w_scl       = 1'b1;
      w_sda_low   = 1'b0;
      case (r_state)
         S_IDLE, S_HOLD: begin
            w_scl     = (r_state == S_IDLE);
            w_sda_low = (r_state == S_HOLD) ? r_sda_low : 1'b0;
            if (ctl.cmd_start) begin
               w_state_nxt = S_START;
            end else if (r_owned) begin
               if (ctl.cmd_stop) begin
                  w_state_nxt = S_STOP;
               end else if (ctl.cmd_write) begin
                  w_state_nxt = S_WBIT;
               end else if (ctl.cmd_read) begin
                  w_state_nxt = S_RBIT;
               end
            end
         end
         S_START: begin
            case (r_quarter)
               2'd0: w_scl = !r_owned;
               2'd1: w_scl = 1'b1;
               2'd2: begin w_scl = 1'b1; w_sda_low = 1'b1; end
               2'd3: begin w_scl = 1'b0; w_sda_low = 1'b1; end
            endcase
            if (w_cell_end) begin
               w_state_nxt = S_HOLD;
               w_finish    = 1'b1;
            end
         end
         S_WBIT: begin
            w_scl     = w_scl_cell;
            w_sda_low = !r_tx[7];
            if (w_cell_end && (r_bit == 3'd7)) w_state_nxt = S_WACK;
         end
         S_WACK: begin
            w_scl = w_scl_cell;
            if (w_cell_end) begin
               w_state_nxt = S_HOLD;
               w_finish    = 1'b1;
            end
         end
         S_RBIT: begin
            w_scl = w_scl_cell;
            if (w_cell_end && (r_bit == 3'd7)) w_state_nxt = S_RACK;
         end
         S_RACK: begin
            w_scl     = w_scl_cell;
            w_sda_low = !r_mack;
            if (w_cell_end) begin
               w_state_nxt = S_HOLD;
               w_finish    = 1'b1;
            end
         end
         S_STOP: begin
            w_scl     = (r_quarter != 2'd0);
            w_sda_low = (r_quarter == 2'd0) || (r_quarter == 2'd1);
            if (w_cell_end) begin
               w_state_nxt = S_IDLE;
               w_finish    = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_qcnt     <= '0;
         r_quarter  <= '0;
         r_bit      <= '0;
         r_tx       <= '0;
         r_rx_sr    <= '0;
         r_rx_data  <= 8'h00;
         r_mack     <= 1'b1;
         r_ack_smp  <= 1'b1;
         r_ack_in   <= 1'b1;
         r_done     <= 1'b0;
         r_owned    <= 1'b0;
         r_scl      <= 1'b1;
         r_sda_low  <= 1'b0;
         r_sda_sync <= 2'b11;
      end else begin
         r_done     <= w_finish;
         r_scl      <= w_scl;
         r_sda_low  <= w_sda_low;
         r_sda_sync <= {r_sda_sync[0], SDA};
         if (w_accept) begin
            r_qcnt    <= '0;
            r_quarter <= '0;
            r_bit     <= '0;
            r_tx      <= ctl.tx_data;
            r_mack    <= ctl.master_ack;
         end else if (!w_idle_like) begin
            r_qcnt <= w_q_last ? 16'd0 : r_qcnt + 16'd1;
            if (w_q_last) r_quarter <= r_quarter + 2'd1;
            // Bit counter wraps 7->0 on entry to the acknowledge cell.
            if (w_cell_end && ((r_state == S_WBIT) || (r_state == S_RBIT)))
               r_bit <= r_bit + 3'd1;
            if (w_cell_end && (r_state == S_WBIT)) r_tx <= {r_tx[6:0], 1'b0};
            if (w_sample && (r_state == S_RBIT)) r_rx_sr <= {r_rx_sr[6:0], r_sda_sync[1]};
            if (w_sample && (r_state == S_WACK)) r_ack_smp <= r_sda_sync[1];
         end
         if (w_finish) begin
            if (r_state == S_START) r_owned   <= 1'b1;
            if (r_state == S_STOP)  r_owned   <= 1'b0;
            if (r_state == S_WACK)  r_ack_in  <= r_ack_smp;
            if (r_state == S_RACK)  r_rx_data <= r_rx_sr;
         end
      end
   end

   assign SCL           = r_scl;
   assign SDA           = r_sda_low ? 1'b0 : 1'bz;
   assign ctl.busy      = !w_idle_like;
   assign ctl.done      = r_done;
   assign ctl.bus_owned = r_owned;
   assign ctl.ack_in    = r_ack_in;
   assign ctl.rx_data   = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
//============================================================================
// Module   : tb_i2c_master
// Brief    : Directed bench for i2c_master with a behavioural 0x24 slave.
// Revision : 1.0 - initial release
//============================================================================
module tb_i2c_master;
   localparam int          CLK_DIV   = 4;
   localparam int          T_QUAD    = 4 * CLK_DIV;
   localparam int          T_BYTE    = 36 * CLK_DIV;
   localparam logic [6:0]  SLV_ADDR  = 7'h24;
   localparam logic [7:0]  C_RD_BYTE = 8'h3C;
   localparam logic [3:0]  C_START   = 4'b1000;
   localparam logic [3:0]  C_STOP    = 4'b0100;
   localparam logic [3:0]  C_WRITE   = 4'b0010;
   localparam logic [3:0]  C_READ    = 4'b0001;

   logic clk = 1'b0;
   logic reset;
   wire  scl;
   wire  sda_bus;
   int   n_checks = 0;
   int   n_fail   = 0;

   i2c_master_if ctl();

   i2c_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (ctl),
      .SCL   (scl),
      .SDA   (sda_bus)
   );

   pullup (sda_bus);

   always #5 clk = ~clk;

   // Slave stage model: 7-bit address 0x24, writes land in s_led, reads return 0x3C.
   logic       s_active, s_skip, s_rw, s_mnack, s_drv, p_scl, p_sda;
   logic [1:0] s_phase;
   logic [3:0] s_bitcnt;
   logic [7:0] s_sr, s_txsr, s_led;

   assign sda_bus = s_drv ? 1'b0 : 1'bz;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s_active <= 1'b0; s_skip <= 1'b0; s_rw <= 1'b0; s_mnack <= 1'b0;
         s_drv <= 1'b0; p_scl <= 1'b1; p_sda <= 1'b1; s_phase <= 2'd0;
         s_bitcnt <= 4'd0; s_sr <= 8'h00; s_txsr <= 8'h00; s_led <= 8'h00;
      end else begin
         p_scl <= scl;
         p_sda <= sda_bus;
         if (scl && p_scl && p_sda && !sda_bus) begin
            s_active <= 1'b1; s_skip <= 1'b1; s_phase <= 2'd0; s_bitcnt <= 4'd0; s_drv <= 1'b0;
         end else if (scl && p_scl && !p_sda && sda_bus) begin
            s_active <= 1'b0; s_drv <= 1'b0;
         end else if (s_active && scl && !p_scl) begin
            if (s_bitcnt < 4'd8 && s_phase != 2'd2) s_sr <= {s_sr[6:0], sda_bus};
            if (s_bitcnt == 4'd8 && s_phase == 2'd2) s_mnack <= sda_bus;
         end else if (s_active && !scl && p_scl) begin
            if (s_skip) begin
               s_skip <= 1'b0;
            end else if (s_bitcnt < 4'd7) begin
               s_bitcnt <= s_bitcnt + 4'd1;
               if (s_phase == 2'd2) begin
                  s_drv  <= !s_txsr[7];
                  s_txsr <= {s_txsr[6:0], 1'b0};
               end
            end else if (s_bitcnt == 4'd7) begin
               s_bitcnt <= 4'd8;
               if (s_phase == 2'd0) begin
                  if (s_sr[7:1] == SLV_ADDR) begin s_drv <= 1'b1; s_rw <= s_sr[0]; end
                  else s_active <= 1'b0;
               end else if (s_phase == 2'd1) begin
                  s_led <= s_sr; s_drv <= 1'b1;
               end else begin
                  s_drv <= 1'b0;
               end
            end else begin
               s_bitcnt <= 4'd0;
               if (s_phase == 2'd0) begin
                  s_phase <= s_rw ? 2'd2 : 2'd1;
                  s_txsr  <= {C_RD_BYTE[6:0], 1'b0};
                  s_drv   <= s_rw ? !C_RD_BYTE[7] : 1'b0;
               end else if (s_phase == 2'd1 || s_mnack) begin
                  s_drv <= 1'b0;
                  if (s_phase == 2'd2) s_active <= 1'b0;
               end else begin
                  s_txsr <= {C_RD_BYTE[6:0], 1'b0};
                  s_drv  <= !C_RD_BYTE[7];
               end
            end
         end
      end
   end

   task automatic clear_strobes();
      ctl.cmd_start = 1'b0; ctl.cmd_stop = 1'b0; ctl.cmd_write = 1'b0; ctl.cmd_read = 1'b0;
   endtask

   // Issues one command and follows it to done, observing the bus on the way.
   task automatic run_cmd(input logic [3:0] cmd, input logic [7:0] data, input logic mack,
                          input bit inject, output int lat, output int period,
                          output bit rstart, output logic sda_ack);
      int   rise0;
      logic pscl, psda;
      @(negedge clk);
      ctl.cmd_start = cmd[3]; ctl.cmd_stop = cmd[2]; ctl.cmd_write = cmd[1]; ctl.cmd_read = cmd[0];
      ctl.tx_data = data; ctl.master_ack = mack;
      @(posedge clk); #1;
      clear_strobes();
      lat = -1; period = 0; rstart = 1'b0; sda_ack = 1'bx; rise0 = -1;
      pscl = scl; psda = sda_bus;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (inject && n == 5) begin
            ctl.cmd_start = 1'b1; ctl.cmd_stop = 1'b1; ctl.cmd_read = 1'b1;
         end else if (inject && n == 6) begin
            clear_strobes();
         end
         if (scl && !pscl) begin
            if (rise0 < 0) rise0 = n;
            else if (period == 0) period = n - rise0;
         end
         if (scl && pscl && psda && !sda_bus) rstart = 1'b1;
         if (n == 34 * CLK_DIV + 2) sda_ack = sda_bus;
         pscl = scl; psda = sda_bus;
         if (ctl.done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int lat, per; bit rs; logic sa;
      reset = 1'b1;
      clear_strobes();
      ctl.tx_data = 8'h00; ctl.master_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_scl: got %b expected 1", scl); end
      n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b expected 1", sda_bus); end
      n_checks++; if (ctl.busy !== 1'b0 || ctl.done !== 1'b0 || ctl.bus_owned !== 1'b0) begin
         n_fail++; $display("FAIL rst_status: busy/done/owned got %b%b%b expected 000", ctl.busy, ctl.done, ctl.bus_owned); end
      n_checks++; if (ctl.rx_data !== 8'h00 || ctl.ack_in !== 1'b1) begin
         n_fail++; $display("FAIL rst_data: rx %h ack %b expected 00/1", ctl.rx_data, ctl.ack_in); end
      @(negedge clk);
      reset = 1'b0;
      run_cmd(C_START, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      @(negedge clk);
      ctl.cmd_write = 1'b1; ctl.tx_data = 8'h48;
      @(posedge clk); #1;
      clear_strobes();
      repeat (20) @(posedge clk);
      #1;
      n_checks++; if (ctl.busy !== 1'b1) begin n_fail++; $display("FAIL midwrite_busy: got %b expected 1", ctl.busy); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (scl !== 1'b1 || sda_bus !== 1'b1) begin
         n_fail++; $display("FAIL midrst_lines: scl %b sda %b expected 1/1", scl, sda_bus); end
      n_checks++; if (ctl.busy !== 1'b0 || ctl.done !== 1'b0 || ctl.bus_owned !== 1'b0) begin
         n_fail++; $display("FAIL midrst_status: busy/done/owned got %b%b%b expected 000", ctl.busy, ctl.done, ctl.bus_owned); end
      n_checks++; if (ctl.rx_data !== 8'h00 || ctl.ack_in !== 1'b1) begin
         n_fail++; $display("FAIL midrst_data: rx %h ack %b expected 00/1", ctl.rx_data, ctl.ack_in); end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write();
      int lat, per; bit rs; logic sa;
      run_cmd(C_START, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_QUAD) begin n_fail++; $display("FAIL start_latency: got %0d expected %0d", lat, T_QUAD); end
      n_checks++; if (ctl.bus_owned !== 1'b1 || ctl.busy !== 1'b0) begin
         n_fail++; $display("FAIL start_owned: owned %b busy %b expected 1/0", ctl.bus_owned, ctl.busy); end
      run_cmd(C_WRITE, 8'h48, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_BYTE) begin n_fail++; $display("FAIL write_latency: got %0d expected %0d", lat, T_BYTE); end
      n_checks++; if (per !== 16) begin n_fail++; $display("FAIL scl_period: got %0d expected 16", per); end
      n_checks++; if (ctl.ack_in !== 1'b0) begin n_fail++; $display("FAIL addr_ack: got %b expected 0", ctl.ack_in); end
      run_cmd(C_WRITE, 8'hA5, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (ctl.ack_in !== 1'b0) begin n_fail++; $display("FAIL data_ack: got %b expected 0", ctl.ack_in); end
      n_checks++; if (s_led !== 8'hA5) begin n_fail++; $display("FAIL slave_led: got %h expected a5", s_led); end
      run_cmd(C_STOP, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_QUAD) begin n_fail++; $display("FAIL stop_latency: got %0d expected %0d", lat, T_QUAD); end
      n_checks++; if (scl !== 1'b1 || sda_bus !== 1'b1 || ctl.bus_owned !== 1'b0) begin
         n_fail++; $display("FAIL stop_idle: scl %b sda %b owned %b expected 1/1/0", scl, sda_bus, ctl.bus_owned); end
   endtask

   task automatic test_mismatch();
      int lat, per; bit rs; logic sa;
      run_cmd(C_START, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      run_cmd(C_WRITE, 8'h50, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (ctl.ack_in !== 1'b1) begin n_fail++; $display("FAIL nack_addr: got %b expected 1", ctl.ack_in); end
      n_checks++; if (s_led !== 8'hA5) begin n_fail++; $display("FAIL led_kept: got %h expected a5", s_led); end
      run_cmd(C_STOP, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_QUAD || ctl.bus_owned !== 1'b0) begin
         n_fail++; $display("FAIL nack_stop: lat %0d owned %b expected %0d/0", lat, ctl.bus_owned, T_QUAD); end
   endtask

   task automatic test_read();
      int lat, per; bit rs; logic sa;
      run_cmd(C_START, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      run_cmd(C_WRITE, 8'h49, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (ctl.ack_in !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b expected 0", ctl.ack_in); end
      run_cmd(C_READ, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_BYTE) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, T_BYTE); end
      n_checks++; if (ctl.rx_data !== 8'h3C) begin n_fail++; $display("FAIL rx_data: got %h expected 3c", ctl.rx_data); end
      n_checks++; if (sa !== 1'b1) begin n_fail++; $display("FAIL read_nack_sda: got %b expected 1", sa); end
      run_cmd(C_STOP, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (ctl.bus_owned !== 1'b0 || ctl.rx_data !== 8'h3C) begin
         n_fail++; $display("FAIL read_stop: owned %b rx %h expected 0/3c", ctl.bus_owned, ctl.rx_data); end
   endtask

   task automatic test_cmd_rules();
      int lat, per; bit rs; logic sa;
      bit bad_done, bad_line, bad_busy;
      @(negedge clk);
      ctl.cmd_write = 1'b1; ctl.tx_data = 8'h48;
      @(posedge clk); #1;
      clear_strobes();
      bad_done = 1'b0; bad_line = 1'b0; bad_busy = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (ctl.done !== 1'b0) bad_done = 1'b1;
         if (ctl.busy !== 1'b0) bad_busy = 1'b1;
         if (scl !== 1'b1 || sda_bus !== 1'b1) bad_line = 1'b1;
      end
      n_checks++; if (bad_done || bad_busy) begin n_fail++; $display("FAIL idle_write_ignored: done %b busy %b expected 0/0", bad_done, bad_busy); end
      n_checks++; if (bad_line) begin n_fail++; $display("FAIL idle_write_lines: disturbed %b expected 0", bad_line); end
      run_cmd(C_START | C_WRITE, 8'hFF, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_QUAD || ctl.bus_owned !== 1'b1) begin
         n_fail++; $display("FAIL start_priority: lat %0d owned %b expected %0d/1", lat, ctl.bus_owned, T_QUAD); end
      run_cmd(C_WRITE, 8'h48, 1'b1, 1'b1, lat, per, rs, sa);
      n_checks++; if (lat !== T_BYTE || ctl.ack_in !== 1'b0 || ctl.bus_owned !== 1'b1) begin
         n_fail++; $display("FAIL busy_ignore: lat %0d ack %b owned %b expected %0d/0/1", lat, ctl.ack_in, ctl.bus_owned, T_BYTE); end
      run_cmd(C_START, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (rs !== 1'b1 || lat !== T_QUAD) begin
         n_fail++; $display("FAIL rep_start: sda_fall_scl_high %b lat %0d expected 1/%0d", rs, lat, T_QUAD); end
      run_cmd(C_WRITE, 8'h48, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (ctl.ack_in !== 1'b0) begin n_fail++; $display("FAIL rep_start_ack: got %b expected 0", ctl.ack_in); end
      n_checks++; if (ctl.rx_data !== 8'h3C) begin n_fail++; $display("FAIL rx_hold: got %h expected 3c", ctl.rx_data); end
      run_cmd(C_STOP, 8'h00, 1'b1, 1'b0, lat, per, rs, sa);
      n_checks++; if (lat !== T_QUAD || ctl.bus_owned !== 1'b0) begin
         n_fail++; $display("FAIL final_stop: lat %0d owned %b expected %0d/0", lat, ctl.bus_owned, T_QUAD); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_cmd_rules();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_master.md
# i2c_master

Byte-level I2C bus master that generates SCL and drives open-drain SDA for the on-board I2C slave stage (`SLV_ADDR` 0x24 LED target). It sits directly upstream of the slave, between a register/command front end and the two-wire bus. It executes one bus primitive per command (START/repeated START, WRITE byte + receive ACK, READ byte + send ACK/NACK, STOP). It reports `busy`/`done`, the captured ACK and the received data. There is no clock stretching and no multi-master arbitration.

## Interface
- `CLK_DIV`, 250: `clk` cycles per SCL quarter-period (100 kHz at 100 MHz). Legal range 4..65535.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_start` in 1: request a START, or a repeated START if the bus is owned.
- `cmd_write` in 1: request a write of `tx_data` and capture of the slave ACK.
- `cmd_read` in 1: request a read of one byte, then drive `master_ack`.
- `cmd_stop` in 1: request a STOP.
- `tx_data` in 8: byte to write, MSB first. Sampled on the accept cycle.
- `master_ack` in 1: ACK bit driven after a read (0=ACK, 1=NACK). Sampled on the accept cycle.
- `rx_data` out 8: last byte read.
- `ack_in` out 1: last ACK bit sampled after a write (0=ACK).
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `bus_owned` out 1: high between a completed START and a completed STOP.
- `SCL` out 1: bus clock, push-pull.
- `SDA` inout 1: open-drain data line; drives 0 or `1'bz` only, external pull-up.

## Operation
- Command accept: on any clock edge where `busy`=0 and at least one strobe is high.
  - Priority order: start > stop > write > read.
  - Strobes are ignored while `busy`=1.
  - `cmd_write`, `cmd_read` or `cmd_stop` with `bus_owned`=0 is ignored: no `busy`, no `done`, lines untouched.
- A quarter counter runs 0..`CLK_DIV`-1. Each quarter q0..q3 lasts `CLK_DIV` cycles.
- FSM states: IDLE, START, WBIT, WACK, RBIT, RACK, STOP, HOLD.
  - HOLD means owned and waiting, with SCL=0 and SDA held at its last value.
- START, 4 quarters:
  - q0: SCL = (`bus_owned` ? 0 : 1), SDA released.
  - q1: SCL=1, SDA released.
  - q2: SCL=1, SDA=0.
  - q3: SCL=0, SDA=0.
  - Then go to HOLD with `bus_owned`=1.
- WBIT, 8 cells, MSB first. Per cell:
  - q0: SCL=0, SDA=bit.
  - q1 and q2: SCL=1, SDA held.
  - q3: SCL=0, SDA held.
- WACK, 1 cell with the same SCL pattern and SDA released. `ack_in` is sampled from SDA on the last cycle of q2. Then go to HOLD.
- RBIT: 8 cells with SDA released. Shift `{sr[6:0],SDA}` on the last cycle of q2.
- RACK: 1 cell driving `master_ack`; 1 means release SDA. `rx_data` loads the shift register at completion. Then go to HOLD.
- STOP, 4 quarters:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2 and q3: SCL=1, SDA released.
  - Then go to IDLE with `bus_owned`=0.
- The SDA input is double-flop synchronized before sampling.
- The bit counter is 3 bits and wraps 7→0 when entering the ACK phase.

## Timing
- Reset values:
  - `SCL`=1, SDA released.
  - `busy`=0, `done`=0, `bus_owned`=0.
  - `rx_data`=8'h00, `ack_in`=1.
  - FSM in IDLE, counters 0.
- `busy` rises on the edge after the accept edge.
- Duration measured from the accept edge to the `done` edge:
  - START and STOP: 4·`CLK_DIV` cycles.
  - WRITE and READ: 36·`CLK_DIV` cycles.
- `done`=1 for exactly one cycle. `busy` falls on the same edge.
- A new command may be accepted in the `done` cycle.
- `ack_in`, `rx_data` and `bus_owned` update on the `done` edge.
- `ack_in` and `rx_data` hold their values until the next write or read completes.
- Reset asserted mid-command: on the next edge (asynchronously), SCL=1 and SDA is released. No STOP sequence is generated. `busy` clears, `done` stays 0.
- SDA changes only while SCL=0. The only exceptions are START q2 and STOP q2.
- SCL high time is 2·`CLK_DIV`; SCL low time is 2·`CLK_DIV` between data cells.

## Test plan
- Reset check: assert `reset` mid-WRITE at `CLK_DIV`=4 → next cycle SCL=1, SDA=z, `busy`=0, `rx_data`=00, `ack_in`=1, `bus_owned`=0.
- Write to the slave stage (`SLV_ADDR`=0x24), sequence START, WRITE 0x48, WRITE 0xA5, STOP:
  - Each WRITE returns `ack_in`=0.
  - Slave `LED`=0xA5 after the second byte.
  - After STOP, SCL=SDA=1 and `bus_owned`=0.
- Address mismatch: START, WRITE 0x50 → `ack_in`=1, slave `LED` unchanged. STOP then completes normally.
- Read against a bench slave model returning 0x3C: START, WRITE 0x49, READ with `master_ack`=1, STOP:
  - `rx_data`=0x3C.
  - SDA released during the 9th cell of the READ (NACK).
- Command rules:
  - WRITE while IDLE → no `done`, lines stay high for 100 cycles.
  - `cmd_start` and `cmd_write` high together → START executed.
  - Strobes pulsed while `busy`=1 are ignored.
  - START while owned performs a repeated START: SDA falls while SCL=1.
- Latency at `CLK_DIV`=4: `done` exactly 16 cycles after START or STOP accept and 144 cycles after WRITE or READ accept. SCL period measures 16 cycles.
